// File: rtl/tnn_core_arbiter_pkg.sv
// Shared types and constants for the TNN neuron-core arbiter slice.
package tnn_pkg;

  localparam int unsigned FEAT_W   = 3;
  localparam int unsigned NUM_FEAT = 6;
  localparam int unsigned IN_W     = NUM_FEAT * FEAT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Feature idx of a packed sample; feature a (idx 0) sits at the LSBs.
  function automatic logic [FEAT_W-1:0] feat_slice(input logic [IN_W-1:0] v,
                                                   input int unsigned    idx);
    return v[idx*FEAT_W +: FEAT_W];
  endfunction

endpackage

// File: rtl/tnn_core_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned N    = 4,
  localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gid
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt   = '0;
    gid   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!found && req[idx[ID_W-1:0]]) begin
        found                = 1'b1;
        gnt[idx[ID_W-1:0]]   = 1'b1;
        gid                  = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tnn_core_arbiter.sv
// Shares one combinational TNN neuron core between NUM_REQ requesters,
// one transaction in flight, round-robin accept order.
module tnn_core_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_FEAT = 6,
  parameter int unsigned FEAT_W   = 3,
  parameter int unsigned CORE_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*NUM_FEAT*FEAT_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic                                 rsp_bit,
  input  logic [NUM_REQ-1:0]                   rsp_ready,
  output logic [NUM_FEAT*FEAT_W-1:0]           core_in,
  input  logic                                 core_out,
  output logic                                 busy,
  output logic [CNT_W-1:0]                     n_done
);

  localparam int unsigned IN_W   = NUM_FEAT * FEAT_W;
  localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WCNT_W = 2;

  typedef tnn_pkg::state_e state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [IN_W-1:0]   core_in_q, core_in_d;
  logic              rsp_bit_q, rsp_bit_d;
  logic [CNT_W-1:0]  n_done_q, n_done_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_gid;
  logic [IN_W-1:0]    acc_data;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .gid (arb_gid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= tnn_pkg::IDLE;
      ptr_q     <= '0;
      gid_q     <= '0;
      wcnt_q    <= '0;
      core_in_q <= '0;
      rsp_bit_q <= 1'b0;
      n_done_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      wcnt_q    <= wcnt_d;
      core_in_q <= core_in_d;
      rsp_bit_q <= rsp_bit_d;
      n_done_q  <= n_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    wcnt_d    = wcnt_q;
    core_in_d = core_in_q;
    rsp_bit_d = rsp_bit_q;
    n_done_d  = n_done_q;
    acc_data  = '0;

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) acc_data = req_data[i*IN_W +: IN_W];
    end

    case (state_q)
      tnn_pkg::IDLE: begin
        if (|req_valid) begin
          core_in_d = acc_data;
          gid_d     = arb_gid;
          wcnt_d    = WCNT_W'(CORE_LAT);
          state_d   = tnn_pkg::WAIT;
        end
      end
      tnn_pkg::WAIT: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 1'b1;
        end else begin
          rsp_bit_d = core_out;
          state_d   = tnn_pkg::RESP;
        end
      end
      tnn_pkg::RESP: begin
        if (rsp_ready[gid_q]) begin
          n_done_d = n_done_q + 1'b1;
          ptr_d    = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
          state_d  = tnn_pkg::IDLE;
        end
      end
      default: state_d = tnn_pkg::IDLE;
    endcase
  end

  // req_ready is combinational from req_valid, so it is also held low while
  // rst_n is asserted to keep every output at its reset value.
  always_comb begin
    req_ready = (state_q == tnn_pkg::IDLE && rst_n) ? arb_gnt : '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (state_q == tnn_pkg::RESP) && (gid_q == ID_W'(i));
    end
    busy = (state_q != tnn_pkg::IDLE);
  end

  assign core_in = core_in_q;
  assign rsp_bit = rsp_bit_q;
  assign n_done  = n_done_q;

endmodule

// File: tb/tb_tnn_core_arbiter.sv
// Directed bench for tnn_core_arbiter with a behavioural neuron driving core_out.
module tb_tnn_core_arbiter;
  import tnn_pkg::*;

  localparam int unsigned NR = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NR-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*IN_W-1:0] req_data;
  logic               rsp_bit, core_out, busy;
  logic [IN_W-1:0]    core_in;
  logic [15:0]        n_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Neuron: weights a:+1 b:-1 c:+1 d:0 e:-1 f:+1, fire when sum > 3.
  function automatic logic tnn_model(input logic [IN_W-1:0] v);
    int s;
    s = int'(feat_slice(v, 0)) - int'(feat_slice(v, 1)) + int'(feat_slice(v, 2))
      - int'(feat_slice(v, 4)) + int'(feat_slice(v, 5));
    return (s > 3);
  endfunction

  assign core_out = tnn_model(core_in);

  tnn_core_arbiter #(
    .NUM_REQ  (NR),
    .NUM_FEAT (6),
    .FEAT_W   (3),
    .CORE_LAT (1),
    .CNT_W    (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_bit   (rsp_bit),
    .rsp_ready (rsp_ready),
    .core_in   (core_in),
    .core_out  (core_out),
    .busy      (busy),
    .n_done    (n_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  logic [IN_W-1:0] d [NR];
  logic            eb [NR];
  int              grants, rsps, last_t, cyc, cur_g;

  initial begin
    d[0] = 18'h2A5A5; eb[0] = 1'b1;
    d[1] = 18'h00000; eb[1] = 1'b0;
    d[2] = 18'h3FFFF; eb[2] = 1'b1;
    d[3] = 18'h00038; eb[3] = 1'b0;

    rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_bit",   32'(rsp_bit),   32'h0);
    chk("rst_core_in",   32'(core_in),   32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_n_done",    32'(n_done),    32'h0);
    rst_n = 1'b1;

    // Single request, latency T -> T+3.
    @(negedge clk);
    req_data[0*IN_W +: IN_W] = 18'h2A5A5; req_valid = 4'b0001; rsp_ready = 4'b1111; #1;
    chk("t2_accept", 32'(req_ready), 32'h1);
    @(negedge clk); req_valid = '0; #1;
    chk("t2_core_in", 32'(core_in), 32'h2A5A5);
    chk("t2_busy_wait", 32'(busy), 32'h1);
    chk("t2_rv_t1", 32'(rsp_valid), 32'h0);
    chk("t2_rr_busy", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("t2_rv_t2", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("t2_rv_t3", 32'(rsp_valid), 32'h1);
    chk("t2_bit", 32'(rsp_bit), 32'h1);
    @(negedge clk);
    chk("t2_rv_t4", 32'(rsp_valid), 32'h0);
    chk("t2_idle", 32'(busy), 32'h0);
    chk("t2_n_done", 32'(n_done), 32'h1);

    // Reset while in WAIT aborts the transaction.
    req_data[1*IN_W +: IN_W] = 18'h2A5A5; req_valid = 4'b0010; #1;
    chk("t1_accept", 32'(req_ready), 32'h2);
    @(negedge clk); req_valid = '0; #1;
    chk("t1_in_wait", 32'(busy), 32'h1);
    rst_n = 1'b0; #1;
    chk("t1_rr",      32'(req_ready), 32'h0);
    chk("t1_rv",      32'(rsp_valid), 32'h0);
    chk("t1_bit",     32'(rsp_bit),   32'h0);
    chk("t1_core_in", 32'(core_in),   32'h0);
    chk("t1_busy",    32'(busy),      32'h0);
    chk("t1_n_done",  32'(n_done),    32'h0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t1_no_rsp", {27'h0, busy, rsp_valid}, 32'h0);
    end

    // All four requesting: order 0,1,2,3,0,1 at a 4-cycle issue interval.
    for (int i = 0; i < int'(NR); i++) req_data[i*IN_W +: IN_W] = d[i];
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    grants = 0; rsps = 0; last_t = 0; cyc = 0; cur_g = 0;
    while (rsps < 6 && cyc < 60) begin
      #1;
      if (|req_ready) begin
        chk("t3_grant", 32'(req_ready), 32'(1 << (grants % 4)));
        chk("t3_not_busy", 32'(busy), 32'h0);
        if (grants > 0) chk("t3_interval", 32'(cyc - last_t), 32'd4);
        last_t = cyc; cur_g = grants % 4; grants++;
      end
      if (|rsp_valid) begin
        chk("t3_rsp_owner", 32'(rsp_valid), 32'(1 << cur_g));
        chk("t3_rsp_bit", 32'(rsp_bit), 32'(eb[cur_g]));
        rsps++;
      end
      if (rsps < 6) @(negedge clk);
      cyc++;
    end
    req_valid = '0;
    chk("t3_grants", 32'(grants), 32'd6);
    chk("t3_rsps", 32'(rsps), 32'd6);

    // Stall requester 1 while requester 0 waits.
    @(negedge clk);
    req_data[1*IN_W +: IN_W] = 18'h2A5A5; req_valid = 4'b0010; rsp_ready = '0; #1;
    chk("t4_accept", 32'(req_ready), 32'h2);
    @(negedge clk); req_valid = 4'b0001; #1;
    chk("t4_no_rr_wait", 32'(req_ready), 32'h0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t4_rv",   32'(rsp_valid), 32'h2);
      chk("t4_bit",  32'(rsp_bit),   32'h1);
      chk("t4_busy", 32'(busy),      32'h1);
      chk("t4_rr",   32'(req_ready), 32'h0);
      @(negedge clk);
    end
    rsp_ready = 4'b0010;
    @(negedge clk); rsp_ready = 4'b0100; #1;
    chk("t4_req0_next", 32'(req_ready), 32'h1);
    chk("t4_n_done", 32'(n_done), 32'd7);

    // Foreign rsp_ready bit is ignored.
    @(negedge clk); req_valid = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t5_rv_held", 32'(rsp_valid), 32'h1);
      chk("t5_n_done",  32'(n_done),    32'd7);
      @(negedge clk);
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    chk("t5_done_rv", 32'(rsp_valid), 32'h0);
    chk("t5_done_n",  32'(n_done),    32'd8);
    chk("t5_idle",    32'(busy),      32'h0);

    // Counter wrap.
    rsp_ready = '0;
    force dut.n_done_q = 16'hFFFF;
    @(negedge clk);
    release dut.n_done_q;
    @(negedge clk);
    chk("t6_preset", 32'(n_done), 32'hFFFF);
    req_data[2*IN_W +: IN_W] = 18'h00038; req_valid = 4'b0100; rsp_ready = 4'b1111; #1;
    chk("t6_accept", 32'(req_ready), 32'h4);
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_rv",  32'(rsp_valid), 32'h4);
    chk("t6_bit", 32'(rsp_bit),   32'h0);
    @(negedge clk);
    chk("t6_wrap", 32'(n_done), 32'h0);
    chk("t6_idle", 32'(busy),   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
